// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED event scheduler: FSM states, animation codes
// and the bit positions of the pending-request vector.
package led_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        RUN,
        GAP
    } sched_state_t;

    localparam logic [1:0] ANIM_GBEST   = 2'd0;
    localparam logic [1:0] ANIM_PBEST   = 2'd1;
    localparam logic [1:0] ANIM_CRASH   = 2'd2;
    localparam logic [1:0] ANIM_LOWFUEL = 2'd3;

    localparam int unsigned PEND_GBEST   = 0;
    localparam int unsigned PEND_PBEST   = 1;
    localparam int unsigned PEND_CRASH   = 2;
    localparam int unsigned PEND_LOWFUEL = 3;

endpackage

// File: rtl/led_event_scheduler_prio_arb.sv
// Combinational fixed-priority picker GBEST > PBEST > CRASH > LOWFUEL;
// the aging flag lets a pending LOWFUEL jump the queue.
import led_sched_pkg::*;

module led_sched_prio_arb (
    input  logic [3:0] pending,
    input  logic       aging,
    output logic       valid,
    output logic [1:0] code
);

    always_comb begin
        valid = |pending;
        code  = ANIM_GBEST;
        if (aging && pending[PEND_LOWFUEL]) begin
            code = ANIM_LOWFUEL;
        end else if (pending[PEND_GBEST]) begin
            code = ANIM_GBEST;
        end else if (pending[PEND_PBEST]) begin
            code = ANIM_PBEST;
        end else if (pending[PEND_CRASH]) begin
            code = ANIM_CRASH;
        end else if (pending[PEND_LOWFUEL]) begin
            code = ANIM_LOWFUEL;
        end
    end

endmodule

// File: rtl/led_event_scheduler.sv
// Latches game events, arbitrates them and drives the LED animator handshake.
// Optional LOWFUEL starvation guard: define LED_SCHED_AGING_EN.
import led_sched_pkg::*;

module led_event_scheduler #(
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned START_TMO  = 4,
    parameter int unsigned RUN_TMO    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_gbest,
    input  logic       ev_pbest,
    input  logic       ev_crash,
    input  logic       ev_lowfuel,
    input  logic       game_active,
    input  logic       anim_busy,
    input  logic       anim_done,
    output logic       anim_start,
    output logic [1:0] anim_sel,
    output logic       gauge_pass,
    output logic [3:0] pending,
    output logic [3:0] coalesced,
    output logic       err
);

    sched_state_t state, state_nx;
    logic [15:0]  timer;
    logic [3:0]   pend_q, pend_nx;
    logic [3:0]   coal_q;
    logic [1:0]   sel_q;
    logic         err_q;
    logic         tmo_hit;

    logic [3:0]   ev;
    logic [3:0]   merged;
    logic [2:0]   merge_cnt;
    logic [4:0]   coal_sum;
    logic [3:0]   grant_clr;
    logic         grant;
    logic         arb_valid;
    logic [1:0]   arb_code;
    logic         aging;

    led_sched_prio_arb u_arb (
        .pending (pend_q),
        .aging   (aging),
        .valid   (arb_valid),
        .code    (arb_code)
    );

    assign grant = (state == ISSUE) && arb_valid;

    // Low-fuel pulses outside a round are dropped before they can latch or merge.
    assign ev        = {ev_lowfuel & game_active, ev_crash, ev_pbest, ev_gbest};
    assign merged    = ev & pend_q;
    assign merge_cnt = {2'b00, merged[0]} + {2'b00, merged[1]}
                     + {2'b00, merged[2]} + {2'b00, merged[3]};
    assign coal_sum  = {1'b0, coal_q} + {2'b00, merge_cnt};

    always_comb begin
        grant_clr = '0;
        if (grant) begin
            grant_clr[arb_code] = 1'b1;
            if (arb_code == ANIM_GBEST) begin
                grant_clr[PEND_PBEST] = 1'b1;
            end
        end
    end

    always_comb begin
        pend_nx = (pend_q | ev) & ~grant_clr;
        if (!game_active) begin
            pend_nx[PEND_LOWFUEL] = 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        tmo_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (|pend_q) state_nx = ISSUE;
            end
            ISSUE: begin
                // A lone LOWFUEL request can vanish when the round ends.
                state_nx = arb_valid ? WAIT_BUSY : IDLE;
            end
            WAIT_BUSY: begin
                if (anim_busy) begin
                    state_nx = RUN;
                end else if (timer == 16'(START_TMO - 1)) begin
                    tmo_hit  = 1'b1;
                    state_nx = GAP;
                end
            end
            RUN: begin
                if (anim_done) begin
                    state_nx = GAP;
                end else if (timer == 16'(RUN_TMO - 1)) begin
                    tmo_hit  = 1'b1;
                    state_nx = GAP;
                end
            end
            GAP: begin
                if (timer == 16'(GAP_CYCLES - 1)) begin
                    state_nx = (|pend_q) ? ISSUE : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            timer  <= '0;
            pend_q <= '0;
            coal_q <= '0;
            sel_q  <= ANIM_GBEST;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            timer  <= (state_nx != state) ? '0 : timer + 16'd1;
            pend_q <= pend_nx;
            coal_q <= coal_sum[4] ? 4'hF : coal_sum[3:0];
            if (grant) sel_q <= arb_code;
            if (tmo_hit) err_q <= 1'b1;
        end
    end

`ifdef LED_SCHED_AGING_EN
    logic [2:0] skip_q;

    assign aging = (skip_q >= 3'd4);

    always_ff @(posedge clk) begin
        if (!rst) begin
            skip_q <= '0;
        end else if (!pend_q[PEND_LOWFUEL]) begin
            skip_q <= '0;
        end else if (grant) begin
            if (arb_code == ANIM_LOWFUEL) begin
                skip_q <= '0;
            end else if (skip_q < 3'd4) begin
                skip_q <= skip_q + 3'd1;
            end
        end
    end
`else
    assign aging = 1'b0;
`endif

    assign anim_start = grant;
    assign anim_sel   = grant ? arb_code : sel_q;
    assign gauge_pass = (state == IDLE);
    assign pending    = pend_q;
    assign coalesced  = coal_q;
    assign err        = err_q;

endmodule

// File: tb/tb_led_event_scheduler.sv
// Directed self-checking bench for led_event_scheduler; expected values are
// hand-derived from the cycle behaviour of the scheduler.
module tb_led_event_scheduler;

    localparam int GAP = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       ev_gbest, ev_pbest, ev_crash, ev_lowfuel;
    logic       game_active, anim_busy, anim_done;
    logic       anim_start;
    logic [1:0] anim_sel;
    logic       gauge_pass;
    logic [3:0] pending;
    logic [3:0] coalesced;
    logic       err;

    int vec_cnt = 0;
    int miscmp  = 0;

    led_event_scheduler #(
        .GAP_CYCLES (GAP),
        .START_TMO  (4),
        .RUN_TMO    (4096)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ev_gbest    (ev_gbest),
        .ev_pbest    (ev_pbest),
        .ev_crash    (ev_crash),
        .ev_lowfuel  (ev_lowfuel),
        .game_active (game_active),
        .anim_busy   (anim_busy),
        .anim_done   (anim_done),
        .anim_start  (anim_start),
        .anim_sel    (anim_sel),
        .gauge_pass  (gauge_pass),
        .pending     (pending),
        .coalesced   (coalesced),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at the ISSUE sample point; leaves the bench at the first RUN sample.
    task automatic start_anim();
        anim_busy = 1'b1;
        tick();
        tick();
    endtask

    // Done and busy-drop together; returns at the first GAP sample.
    task automatic finish_anim();
        anim_done = 1'b1;
        anim_busy = 1'b0;
        tick();
        anim_done = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!anim_start && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic measure_gap(output int n);
        n = 0;
        while (!gauge_pass && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic pulse(input logic [3:0] evs);
        {ev_lowfuel, ev_crash, ev_pbest, ev_gbest} = evs;
        tick();
        {ev_lowfuel, ev_crash, ev_pbest, ev_gbest} = 4'b0000;
    endtask

    task automatic check_reset_vals(input string tag);
        check_vec({tag, "_start"},   16'(anim_start), 16'd0);
        check_vec({tag, "_sel"},     16'(anim_sel),   16'd0);
        check_vec({tag, "_gauge"},   16'(gauge_pass), 16'd1);
        check_vec({tag, "_pending"}, 16'(pending),    16'd0);
        check_vec({tag, "_coal"},    16'(coalesced),  16'd0);
        check_vec({tag, "_err"},     16'(err),        16'd0);
    endtask

    int n;
    logic [1:0] exp_sel;

    initial begin
        rst = 1'b0;
        {ev_lowfuel, ev_crash, ev_pbest, ev_gbest} = 4'b0000;
        game_active = 1'b1;
        anim_busy   = 1'b0;
        anim_done   = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");
        rst = 1'b1;
        tick();

        // Single PBEST: latency 2, gap of 16 then back to gauge.
        pulse(4'b0010);
        check_vec("pb_pend", 16'(pending), 16'b0010);
        check_vec("pb_c1_start", 16'(anim_start), 16'd0);
        tick();
        check_vec("pb_c2_start", 16'(anim_start), 16'd1);
        check_vec("pb_c2_sel", 16'(anim_sel), 16'd1);
        check_vec("pb_c2_gauge", 16'(gauge_pass), 16'd0);
        start_anim();
        check_vec("pb_run_pend", 16'(pending), 16'd0);
        check_vec("pb_run_sel", 16'(anim_sel), 16'd1);
        finish_anim();
        measure_gap(n);
        check_vec("pb_gap_len", 16'(n), 16'(GAP));
        check_vec("pb_idle_gauge", 16'(gauge_pass), 16'd1);

        // Stray done while idle is ignored.
        anim_done = 1'b1;
        tick();
        anim_done = 1'b0;
        tick();
        check_vec("stray_done_start", 16'(anim_start), 16'd0);
        check_vec("stray_done_gauge", 16'(gauge_pass), 16'd1);

        // GBEST and PBEST together: GBEST only, PBEST absorbed.
        pulse(4'b0011);
        check_vec("gp_pend", 16'(pending), 16'b0011);
        tick();
        check_vec("gp_start", 16'(anim_start), 16'd1);
        check_vec("gp_sel", 16'(anim_sel), 16'd0);
        start_anim();
        check_vec("gp_run_pend", 16'(pending), 16'd0);
        finish_anim();
        measure_gap(n);
        check_vec("gp_gap_len", 16'(n), 16'(GAP));
        tick();
        check_vec("gp_no_follow", 16'(anim_start), 16'd0);
        check_vec("gp_coal", 16'(coalesced), 16'd0);

        // Three CRASH pulses during a GBEST run: two merges, CRASH follows.
        pulse(4'b0001);
        tick();
        check_vec("cr_gb_sel", 16'(anim_sel), 16'd0);
        start_anim();
        for (int i = 0; i < 3; i++) begin
            pulse(4'b0100);
            tick();
        end
        check_vec("cr_coal", 16'(coalesced), 16'd2);
        check_vec("cr_pend", 16'(pending), 16'b0100);
        check_vec("cr_sel_held", 16'(anim_sel), 16'd0);
        finish_anim();
        wait_start(n);
        check_vec("cr_gap_len", 16'(n), 16'(GAP));
        check_vec("cr_sel", 16'(anim_sel), 16'd2);
        start_anim();
        finish_anim();
        measure_gap(n);
        check_vec("cr_end_pend", 16'(pending), 16'd0);

        // Start timeout: no busy, err after 4 WAIT_BUSY cycles, CRASH still issued.
        pulse(4'b0110);
        tick();
        check_vec("to_sel", 16'(anim_sel), 16'd1);
        repeat (4) tick();
        check_vec("to_err_before", 16'(err), 16'd0);
        tick();
        check_vec("to_err_after", 16'(err), 16'd1);
        check_vec("to_gauge", 16'(gauge_pass), 16'd0);
        wait_start(n);
        check_vec("to_gap_len", 16'(n), 16'(GAP));
        check_vec("to_next_sel", 16'(anim_sel), 16'd2);
        start_anim();
        finish_anim();
        measure_gap(n);
        check_vec("to_err_sticky", 16'(err), 16'd1);

        // LOWFUEL outside a round is ignored.
        game_active = 1'b0;
        pulse(4'b1000);
        check_vec("lf_inactive_pend", 16'(pending), 16'd0);
        tick();
        tick();
        check_vec("lf_inactive_start", 16'(anim_start), 16'd0);
        game_active = 1'b1;

        // Reset mid-RUN with a pending CRASH and PBEST selected.
        pulse(4'b0010);
        tick();
        start_anim();
        pulse(4'b0100);
        check_vec("mr_pend_before", 16'(pending), 16'b0100);
        rst = 1'b0;
        anim_busy = 1'b0;
        tick();
        check_reset_vals("mid_rst");
        rst = 1'b1;
        tick();
        tick();
        check_vec("mr_quiet", 16'(anim_start), 16'd0);

        // LOWFUEL against a stream of CRASH requests.
        pulse(4'b1100);
        for (int g = 1; g <= 6; g++) begin
            wait_start(n);
`ifdef LED_SCHED_AGING_EN
            exp_sel = (g == 5) ? 2'd3 : 2'd2;
`else
            exp_sel = (g == 6) ? 2'd3 : 2'd2;
`endif
            check_vec($sformatf("age_g%0d_start", g), 16'(anim_start), 16'd1);
            check_vec($sformatf("age_g%0d_sel", g), 16'(anim_sel), 16'(exp_sel));
            start_anim();
            if (g <= 4) pulse(4'b0100);
            finish_anim();
        end
        measure_gap(n);
        check_vec("age_end_pend", 16'(pending), 16'd0);
        check_vec("age_end_gauge", 16'(gauge_pass), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule

// File: doc/led_event_scheduler.md
Name: led_event_scheduler

Overview:
- Sequences LED-bar animations for the asteroid-dodging game. It owns the single LED animator engine and decides what the bar shows at any time.
- Latches one-cycle event pulses from game logic (global best, personal best, crash, low fuel) and arbitrates them by fixed priority. It issues one animation at a time over a start/busy/done handshake.
- Between animations it enforces a blank gap. When nothing is pending, it hands the bar back to the fuel-gauge passthrough.

Parameters:
- GAP_CYCLES, 16, idle cycles between the end of one animation and the next grant. Allowed range 1..255.
- START_TMO, 4, cycles allowed for anim_busy to rise after anim_start.
- RUN_TMO, 4096, maximum cycles anim_busy may stay high before the scheduler aborts.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- ev_gbest  in  1  one-cycle pulse: new global high score
- ev_pbest  in  1  one-cycle pulse: new personal high score
- ev_crash  in  1  one-cycle pulse: ship collision
- ev_lowfuel  in  1  one-cycle pulse: fuel crossed the low threshold
- game_active  in  1  high while a round is in progress
- anim_busy  in  1  animator is running
- anim_done  in  1  one-cycle pulse: animator finished
- anim_start  out  1  one-cycle pulse: launch animation
- anim_sel  out  2  animation code: 0 = GBEST, 1 = PBEST, 2 = CRASH, 3 = LOWFUEL. Held stable from anim_start until anim_done.
- gauge_pass  out  1  1 = the LED bar shows the fuel gauge
- pending  out  4  latched requests; bit order {lowfuel, crash, pbest, gbest}
- coalesced  out  4  saturating count of events merged into an already-pending request
- err  out  1  sticky; set on any handshake timeout

Behaviour:
- Reset values: anim_start = 0, anim_sel = 0, gauge_pass = 1, pending = 0, coalesced = 0, err = 0, state = IDLE, all timers = 0. Reset mid-animation also drops every pending request; the animator is reset by the same rst.
- Latching:
  - An event pulse sets its pending bit on the next edge.
  - A pulse whose bit is already set, or set in the same cycle as its grant, is merged. Merging increments coalesced, saturating at 15.
  - When game_active is low, lowfuel pulses are ignored and pending[3] is cleared.
- Priority: GBEST > PBEST > CRASH > LOWFUEL.
  - Granting GBEST also clears pending PBEST, because a global best implies a personal best.
- States:
  - IDLE: gauge_pass = 1. If pending != 0, go to ISSUE next cycle.
  - ISSUE: gauge_pass = 0. Drive anim_start = 1 for exactly one cycle with anim_sel = the winner, and clear the winner's pending bit. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for anim_busy = 1, then go to RUN. If START_TMO cycles pass without it, set err and go to GAP.
  - RUN: on anim_done, go to GAP. A done and a busy-drop in the same cycle count as one completion. If RUN_TMO cycles pass without done, set err and go to GAP.
  - GAP: gauge_pass = 0 and the bar is blank. Count GAP_CYCLES. Then go to ISSUE if pending != 0, otherwise IDLE.
- Latency: event pulse at cycle 0 while IDLE gives anim_start at cycle 2.
- Events arriving during ISSUE, WAIT_BUSY, RUN or GAP are only latched; they never preempt the running animation.
- A stray anim_done outside RUN is ignored.
- Timers are 16-bit and are cleared on every state entry.

Optional Feature:
- Macro: LED_SCHED_AGING_EN.
- Enabled: a 3-bit skip counter increments each time LOWFUEL is pending but loses arbitration. At 4 skips, LOWFUEL wins the next grant regardless of priority and the counter clears.
- Disabled: strict fixed priority; LOWFUEL can starve.

Decomposition:
- Shared package led_sched_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT_BUSY, RUN, GAP);
  - the anim_sel codes (ANIM_GBEST = 0, ANIM_PBEST = 1, ANIM_CRASH = 2, ANIM_LOWFUEL = 3);
  - the pending bit indices.
- Sub-module led_sched_prio_arb: combinational fixed-priority picker (plus the aging override when enabled). Inputs: pending and the aging flag. Outputs: valid and the 2-bit code.

Test Plan:
- Single ev_pbest at cycle 0 while IDLE -> anim_start at cycle 2 with anim_sel = 1; gauge_pass returns to 1 exactly GAP_CYCLES = 16 cycles after anim_done.
- ev_gbest and ev_pbest in the same cycle -> one animation with anim_sel = 0, pending = 0 afterwards, no PBEST animation follows.
- ev_crash three times during a GBEST RUN -> coalesced = 2, a CRASH animation follows after the gap, pending = 0 at end.
- Hold anim_busy low after anim_start -> err = 1 after 4 cycles, GAP entered, next pending request still issued.
- ev_lowfuel with game_active = 0 -> pending stays 0, no anim_start; assert rst low during RUN -> all outputs at reset values on the next edge.
- Aging enabled: pending LOWFUEL skipped 4 times by repeated CRASH events -> 5th grant has anim_sel = 3; aging disabled: LOWFUEL waits until CRASH stops.
